unified_buffer: RTL

On-chip unified buffer for the TinyML accelerator: a single-port synchronous word memory that answers the accelerator core's `uni_*` access port. It also exposes a host-side burst port that loads input matrices before `start` and dumps results after `done`. The host engine owns the memory while a burst runs; core accesses during that time are stalled and dropped.

---
 rtl/unified_buffer.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/unified_buffer.sv
// unified_buffer: single-port word memory shared by the core uni_* port
// and a host burst engine that loads inputs and dumps results.
`ifndef WORD_SIZE
`define WORD_SIZE 16
`endif

module unified_buffer #(
   parameter int DEPTH  = 256,
   parameter int ADDR_W = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  uni_wen,
   input  logic                  uni_ren,
   input  logic [`WORD_SIZE-1:0] uni_addr,
   input  logic [`WORD_SIZE-1:0] uni_wdata,
   output logic [`WORD_SIZE-1:0] uni_rdata,
   output logic                  uni_rvalid,
   output logic                  uni_stall,
   input  logic                  host_wr_start,
   input  logic                  host_rd_start,
   input  logic [ADDR_W-1:0]     host_base,
   input  logic [ADDR_W:0]       host_len,
   input  logic                  host_wvalid,
   input  logic [`WORD_SIZE-1:0] host_wdata,
   output logic                  host_wready,
   output logic                  host_rvalid,
   output logic [`WORD_SIZE-1:0] host_rdata,
   input  logic                  host_rready,
   output logic                  host_done,
   output logic                  err
);
   localparam int W = `WORD_SIZE;
   localparam logic [W:0]      DEPTH_W = DEPTH;
   localparam logic [ADDR_W:0] CNT_ONE = 1;
   localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(DEPTH - 1);

   typedef enum logic [2:0] {
      IDLE, LOAD, DUMP_RD, DUMP_OUT, DONE
   } state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d, ptr_inc;
   logic [ADDR_W:0]   cnt_q, cnt_d;
   logic [W-1:0]      mem [DEPTH];
   logic [W-1:0]      uni_rdata_q, host_rdata_q;
   logic              uni_rvalid_q, err_q;

   logic              idle, in_range;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [W-1:0]      mem_wdata;

   assign idle     = (state_q == IDLE);
   assign in_range = {1'b0, uni_addr} < DEPTH_W;
   assign ptr_inc  = (ptr_q == PTR_LAST) ? '0 : ptr_q + 1'b1;

   // Single memory port: core owns it in IDLE, host engine otherwise.
   always_comb begin
      mem_we    = 1'b0;
      mem_addr  = uni_addr[ADDR_W-1:0];
      mem_wdata = uni_wdata;
      unique case (state_q)
         IDLE: mem_we = uni_wen & in_range;
         LOAD: begin
            mem_we    = host_wvalid;
            mem_addr  = ptr_q;
            mem_wdata = host_wdata;
         end
         DUMP_RD: mem_addr = ptr_q;
         default: ;
      endcase
      mem_we = mem_we & ~reset;
   end

   // Memory array write; contents survive reset.
   always_ff @(posedge clk) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
   end

   // Burst FSM next-state, pointer and word count.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (host_wr_start || host_rd_start) begin
               ptr_d = host_base;
               cnt_d = host_len;
               if (host_len == '0)    state_d = DONE;
               else if (host_wr_start) state_d = LOAD;
               else                    state_d = DUMP_RD;
            end
         end
         LOAD: begin
            if (host_wvalid) begin
               ptr_d = ptr_inc;
               cnt_d = cnt_q - 1'b1;
               if (cnt_q == CNT_ONE) state_d = DONE;
            end
         end
         DUMP_RD: begin
            ptr_d   = ptr_inc;
            state_d = DUMP_OUT;
         end
         DUMP_OUT: begin
            if (host_rready) begin
               cnt_d   = cnt_q - 1'b1;
               state_d = (cnt_q == CNT_ONE) ? DONE : DUMP_RD;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
      end
   end

   // Registered read data for both ports plus range-error pulse.
   always_ff @(posedge clk) begin
      if (reset) begin
         uni_rdata_q  <= '0;
         uni_rvalid_q <= 1'b0;
         err_q        <= 1'b0;
         host_rdata_q <= '0;
      end else begin
         uni_rvalid_q <= idle & uni_ren;
         err_q        <= idle & (uni_ren | uni_wen) & ~in_range;
         if (idle & uni_ren)
            uni_rdata_q <= in_range ? mem[mem_addr] : '0;
         if (state_q == DUMP_RD)
            host_rdata_q <= mem[mem_addr];
      end
   end

   assign uni_rdata   = uni_rdata_q;
   assign uni_rvalid  = uni_rvalid_q;
   assign err         = err_q;
   assign uni_stall   = ~idle;
   assign host_wready = (state_q == LOAD);
   assign host_rvalid = (state_q == DUMP_OUT);
   assign host_rdata  = host_rdata_q;
   assign host_done   = (state_q == DONE);

endmodule
